// File: rtl/hci_package.sv
// Shared definitions for the HCI core elastic slice: request payload layout and
// elaboration-time legality helpers for the slice parameters.
package hci_package;

  localparam int unsigned HCI_DW   = 32;
  localparam int unsigned HCI_AW   = 32;
  localparam int unsigned HCI_BW   = 8;
  localparam int unsigned HCI_UW   = 1;
  localparam int unsigned HCI_BE_W = HCI_DW / HCI_BW;

  typedef struct packed {
    logic [HCI_AW-1:0]   add;
    logic                we_n;
    logic [HCI_DW-1:0]   data;
    logic [HCI_BE_W-1:0] be;
    logic [HCI_BE_W-1:0] boffs;
    logic                lrdy;
    logic [HCI_UW-1:0]   user;
  } hci_req_payload_t;

  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= 32'd1) && (depth <= 32'd8);
  endfunction

  function automatic bit resp_reg_legal(input int unsigned resp_reg);
    return resp_reg <= 32'd1;
  endfunction

endpackage

// File: rtl/hci_core_intf.sv
// TCDM-style core interface: request channel (req/gnt plus payload) and
// response channel (r_*), with master and slave views.
interface hci_core_intf #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32,
  parameter int unsigned BW = 8,
  parameter int unsigned UW = 1
);
  logic             req;
  logic             gnt;
  logic [AW-1:0]    add;
  logic             we_n;
  logic [DW-1:0]    data;
  logic [DW/BW-1:0] be;
  logic [DW/BW-1:0] boffs;
  logic             lrdy;
  logic [UW-1:0]    user;
  logic [DW-1:0]    r_data;
  logic             r_valid;
  logic             r_opc;
  logic [UW-1:0]    r_user;

  modport master (
    output req, add, we_n, data, be, boffs, lrdy, user,
    input  gnt, r_data, r_valid, r_opc, r_user
  );

  modport slave (
    input  req, add, we_n, data, be, boffs, lrdy, user,
    output gnt, r_data, r_valid, r_opc, r_user
  );
endinterface

// File: rtl/hci_core_req_fifo.sv
// Request buffer for the elastic slice: DEPTH-entry circular FIFO whose full flag
// depends only on registered occupancy. Storage is not reset.
module hci_core_req_fifo
  import hci_package::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter type         payload_t = hci_req_payload_t
) (
  input  logic     clk_i,
  input  logic     clear_i,
  input  logic     push,
  input  payload_t wdata,
  output logic     full,
  input  logic     pop,
  output payload_t rdata,
  output logic     empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  payload_t         mem_r [DEPTH];
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] wptr_nxt_s;
  logic [PTR_W-1:0] rptr_r;
  logic [PTR_W-1:0] rptr_nxt_s;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == CNT_FULL);
  assign empty  = (count_r == {CNT_W{1'b0}});
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;
  assign rdata  = mem_r[rptr_r];

  // Occupancy and pointer next-state; pointers wrap explicitly since DEPTH need not be a power of two.
  always_comb begin
    count_nxt_s = count_r;
    wptr_nxt_s  = wptr_r;
    rptr_nxt_s  = rptr_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
      default: count_nxt_s = count_r;
    endcase
    if (push_s) begin
      wptr_nxt_s = (wptr_r == PTR_LAST) ? {PTR_W{1'b0}} : wptr_r + PTR_W'(1'b1);
    end else begin
      wptr_nxt_s = wptr_r;
    end
    if (pop_s) begin
      rptr_nxt_s = (rptr_r == PTR_LAST) ? {PTR_W{1'b0}} : rptr_r + PTR_W'(1'b1);
    end else begin
      rptr_nxt_s = rptr_r;
    end
  end

  // Control state register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      count_r <= {CNT_W{1'b0}};
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
    end else begin
      count_r <= count_nxt_s;
      wptr_r  <= wptr_nxt_s;
      rptr_r  <= rptr_nxt_s;
    end
  end

  // Payload storage write.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/hci_core_elastic_slice.sv
// Elastic slice on an HCI core link: buffers requests in a small FIFO (breaking the
// gnt path) and optionally registers the response channel.
module hci_core_elastic_slice
  import hci_package::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RESP_REG = 1,
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 32,
  parameter int unsigned BW       = 8,
  parameter int unsigned UW       = 1
) (
  input logic          clk_i,
  input logic          clear_i,
  hci_core_intf.slave  tcdm_slave,
  hci_core_intf.master tcdm_master
);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("hci_core_elastic_slice: DEPTH must be in 1..8");
  end
  if (!resp_reg_legal(RESP_REG)) begin : g_bad_resp_reg
    $error("hci_core_elastic_slice: RESP_REG must be 0 or 1");
  end
  if ((DW != HCI_DW) || (AW != HCI_AW) || (BW != HCI_BW) || (UW != HCI_UW)) begin : g_bad_widths
    $error("hci_core_elastic_slice: DW/AW/BW/UW must match the hci_package payload layout");
  end

  hci_req_payload_t push_payload_s;
  hci_req_payload_t head_payload_s;
  logic             full_s;
  logic             empty_s;

  assign push_payload_s.add   = tcdm_slave.add;
  assign push_payload_s.we_n  = tcdm_slave.we_n;
  assign push_payload_s.data  = tcdm_slave.data;
  assign push_payload_s.be    = tcdm_slave.be;
  assign push_payload_s.boffs = tcdm_slave.boffs;
  assign push_payload_s.lrdy  = tcdm_slave.lrdy;
  assign push_payload_s.user  = tcdm_slave.user;

  hci_core_req_fifo #(
    .DEPTH     (DEPTH),
    .payload_t (hci_req_payload_t)
  ) i_req_fifo (
    .clk_i   (clk_i),
    .clear_i (clear_i),
    .push    (tcdm_slave.req),
    .wdata   (push_payload_s),
    .full    (full_s),
    .pop     (tcdm_master.gnt),
    .rdata   (head_payload_s),
    .empty   (empty_s)
  );

  // Grant comes from registered occupancy only, never from downstream gnt.
  assign tcdm_slave.gnt    = ~full_s;
  assign tcdm_master.req   = ~empty_s;
  assign tcdm_master.add   = head_payload_s.add;
  assign tcdm_master.we_n  = head_payload_s.we_n;
  assign tcdm_master.data  = head_payload_s.data;
  assign tcdm_master.be    = head_payload_s.be;
  assign tcdm_master.boffs = head_payload_s.boffs;
  assign tcdm_master.lrdy  = head_payload_s.lrdy;
  assign tcdm_master.user  = head_payload_s.user;

  if (RESP_REG == 32'd1) begin : g_resp_reg
    logic [DW-1:0] r_data_r;
    logic          r_valid_r;
    logic          r_opc_r;
    logic [UW-1:0] r_user_r;

    // One-stage response register, independent of the request buffer.
    always_ff @(posedge clk_i) begin
      if (clear_i) begin
        r_data_r  <= {DW{1'b0}};
        r_valid_r <= 1'b0;
        r_opc_r   <= 1'b0;
        r_user_r  <= {UW{1'b0}};
      end else begin
        r_data_r  <= tcdm_master.r_data;
        r_valid_r <= tcdm_master.r_valid;
        r_opc_r   <= tcdm_master.r_opc;
        r_user_r  <= tcdm_master.r_user;
      end
    end

    assign tcdm_slave.r_data  = r_data_r;
    assign tcdm_slave.r_valid = r_valid_r;
    assign tcdm_slave.r_opc   = r_opc_r;
    assign tcdm_slave.r_user  = r_user_r;
  end else begin : g_resp_comb
    assign tcdm_slave.r_data  = tcdm_master.r_data;
    assign tcdm_slave.r_valid = tcdm_master.r_valid;
    assign tcdm_slave.r_opc   = tcdm_master.r_opc;
    assign tcdm_slave.r_user  = tcdm_master.r_user;
  end

endmodule

// File: tb/tb_hci_core_elastic_slice.sv
// Directed self-checking bench for hci_core_elastic_slice: three instances cover
// DEPTH=2/RESP_REG=1, DEPTH=3/RESP_REG=0 and DEPTH=4/RESP_REG=1.
module tb_hci_core_elastic_slice;

  logic clk = 1'b0;
  logic clear2 = 1'b1;
  logic clear3 = 1'b1;
  logic clear4 = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(1)) s2 ();
  hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(1)) m2 ();
  hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(1)) s3 ();
  hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(1)) m3 ();
  hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(1)) s4 ();
  hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(1)) m4 ();

  hci_core_elastic_slice #(.DEPTH(2), .RESP_REG(1), .DW(32), .AW(32), .BW(8), .UW(1))
    dut2 (.clk_i(clk), .clear_i(clear2), .tcdm_slave(s2), .tcdm_master(m2));
  hci_core_elastic_slice #(.DEPTH(3), .RESP_REG(0), .DW(32), .AW(32), .BW(8), .UW(1))
    dut3 (.clk_i(clk), .clear_i(clear3), .tcdm_slave(s3), .tcdm_master(m3));
  hci_core_elastic_slice #(.DEPTH(4), .RESP_REG(1), .DW(32), .AW(32), .BW(8), .UW(1))
    dut4 (.clk_i(clk), .clear_i(clear4), .tcdm_slave(s4), .tcdm_master(m4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input bit rnd);
    s2.req = rnd ? 1'($urandom) : 1'b0;  s2.add = rnd ? $urandom : 32'h0;
    s2.we_n = 1'b0; s2.data = rnd ? $urandom : 32'h0; s2.be = 4'h0; s2.boffs = 4'h0;
    s2.lrdy = 1'b1; s2.user = 1'b0;
    m2.gnt = rnd ? 1'($urandom) : 1'b0; m2.r_valid = rnd ? 1'($urandom) : 1'b0;
    m2.r_data = rnd ? $urandom : 32'h0; m2.r_opc = 1'b0; m2.r_user = 1'b0;
    s3.req = rnd ? 1'($urandom) : 1'b0;  s3.add = rnd ? $urandom : 32'h0;
    s3.we_n = 1'b0; s3.data = 32'h0; s3.be = 4'h0; s3.boffs = 4'h0;
    s3.lrdy = 1'b1; s3.user = 1'b0;
    m3.gnt = rnd ? 1'($urandom) : 1'b0; m3.r_valid = rnd ? 1'($urandom) : 1'b0;
    m3.r_data = rnd ? $urandom : 32'h0; m3.r_opc = 1'b0; m3.r_user = 1'b0;
    s4.req = rnd ? 1'($urandom) : 1'b0;  s4.add = rnd ? $urandom : 32'h0;
    s4.we_n = 1'b0; s4.data = 32'h0; s4.be = 4'h0; s4.boffs = 4'h0;
    s4.lrdy = 1'b1; s4.user = 1'b0;
    m4.gnt = rnd ? 1'($urandom) : 1'b0; m4.r_valid = rnd ? 1'($urandom) : 1'b0;
    m4.r_data = rnd ? $urandom : 32'h0; m4.r_opc = 1'b0; m4.r_user = 1'b0;
  endtask

  initial begin
    // Reset held two cycles with random inputs on every port.
    drive_all(1'b1);
    tick();
    drive_all(1'b1);
    tick();
    clear2 = 1'b0; clear3 = 1'b0; clear4 = 1'b0;
    drive_all(1'b0);
    tick();
    check("rst_d2_mreq", 32'(m2.req), 32'd0);
    check("rst_d2_sgnt", 32'(s2.gnt), 32'd1);
    check("rst_d2_rvalid", 32'(s2.r_valid), 32'd0);
    check("rst_d3_mreq", 32'(m3.req), 32'd0);
    check("rst_d3_sgnt", 32'(s3.gnt), 32'd1);
    check("rst_d4_mreq", 32'(m4.req), 32'd0);
    check("rst_d4_sgnt", 32'(s4.gnt), 32'd1);
    check("rst_d4_rvalid", 32'(s4.r_valid), 32'd0);

    // Fill DEPTH=2 with downstream stalled.
    s2.req = 1'b1; s2.add = 32'h100; s2.data = 32'hA5A5_0001; s2.we_n = 1'b0; s2.be = 4'hF;
    #1;
    check("fill_gnt0", 32'(s2.gnt), 32'd1);
    tick();
    check("fill_lat1_req", 32'(m2.req), 32'd1);
    check("fill_lat1_add", m2.add, 32'h100);
    check("fill_gnt1", 32'(s2.gnt), 32'd1);
    s2.add = 32'h104; s2.data = 32'hA5A5_0002; s2.we_n = 1'b1; s2.be = 4'h3;
    tick();
    check("full_gnt", 32'(s2.gnt), 32'd0);
    check("full_add", m2.add, 32'h100);
    s2.add = 32'h108;  // must be refused while full
    tick();
    check("full_hold_gnt", 32'(s2.gnt), 32'd0);
    check("full_hold_add", m2.add, 32'h100);
    check("full_hold_data", m2.data, 32'hA5A5_0001);

    // Drain in order.
    s2.req = 1'b0; m2.gnt = 1'b1;
    tick();
    check("drain_gnt_back", 32'(s2.gnt), 32'd1);
    check("drain_req1", 32'(m2.req), 32'd1);
    check("drain_add1", m2.add, 32'h104);
    check("drain_data1", m2.data, 32'hA5A5_0002);
    check("drain_wen1", 32'(m2.we_n), 32'd1);
    check("drain_be1", 32'(m2.be), 32'h3);
    tick();
    check("drain_empty", 32'(m2.req), 32'd0);
    m2.gnt = 1'b0;

    // Registered response path.
    m2.r_valid = 1'b1; m2.r_data = 32'hDEAD_BEEF; m2.r_opc = 1'b1; m2.r_user = 1'b1;
    #1;
    check("rsp_reg_notyet", 32'(s2.r_valid), 32'd0);
    tick();
    check("rsp_reg_valid", 32'(s2.r_valid), 32'd1);
    check("rsp_reg_data", s2.r_data, 32'hDEAD_BEEF);
    check("rsp_reg_opc", 32'(s2.r_opc), 32'd1);
    check("rsp_reg_user", 32'(s2.r_user), 32'd1);
    m2.r_valid = 1'b0; m2.r_data = 32'h0; m2.r_opc = 1'b0; m2.r_user = 1'b0;
    tick();
    check("rsp_reg_drop", 32'(s2.r_valid), 32'd0);

    // Combinational response path.
    m3.r_valid = 1'b1; m3.r_data = 32'hDEAD_BEEF;
    #1;
    check("rsp_comb_valid", 32'(s3.r_valid), 32'd1);
    check("rsp_comb_data", s3.r_data, 32'hDEAD_BEEF);
    m3.r_valid = 1'b0; m3.r_data = 32'h0;
    #1;
    check("rsp_comb_drop", 32'(s3.r_valid), 32'd0);

    // DEPTH=3: hold occupancy at 1 with push+pop every cycle.
    s3.req = 1'b1; s3.add = 32'h1000;
    tick();
    m3.gnt = 1'b1;
    for (int i = 0; i < 100; i++) begin
      check("pp_req", 32'(m3.req), 32'd1);
      check("pp_add", m3.add, 32'h1000 + 32'(4 * i));
      check("pp_gnt", 32'(s3.gnt), 32'd1);
      s3.add = 32'h1000 + 32'(4 * (i + 1));
      tick();
    end
    s3.req = 1'b0;
    check("pp_last_add", m3.add, 32'h1190);
    tick();
    check("pp_count1", 32'(m3.req), 32'd0);
    m3.gnt = 1'b0;

    // DEPTH=4: buffer three entries, then clear mid-operation.
    s4.req = 1'b1;
    s4.add = 32'h300; tick();
    s4.add = 32'h304; tick();
    s4.add = 32'h308; tick();
    s4.req = 1'b0;
    check("mc_pre_req", 32'(m4.req), 32'd1);
    check("mc_pre_add", m4.add, 32'h300);
    check("mc_pre_gnt", 32'(s4.gnt), 32'd1);
    clear4 = 1'b1;
    tick();
    clear4 = 1'b0;
    check("mc_req0", 32'(m4.req), 32'd0);
    check("mc_gnt1", 32'(s4.gnt), 32'd1);
    s4.req = 1'b1; s4.add = 32'h200;
    tick();
    s4.req = 1'b0;
    check("mc_new_req", 32'(m4.req), 32'd1);
    check("mc_new_add", m4.add, 32'h200);
    m4.gnt = 1'b1;
    tick();
    check("mc_only_one", 32'(m4.req), 32'd0);
    m4.gnt = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
